truth_table_sweeper: RTL and testbench



---
 rtl/truth_table_sweeper.sv | 140 ++++++++++++++
 tb/tb_truth_table_sweeper.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: sweeps all 2^N_IN input vectors onto a shared stimulus
// bus, waits SETTLE cycles per vector, then captures the SOP and POS
// implementation outputs and checks them against an expected truth table.
//
// Handshake: start is level-sampled only in IDLE. busy is high from the start
// edge up to the final sample edge. done pulses for exactly one cycle after the
// final sample. Results hold until the next start or reset.
module truth_table_sweeper #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [(1<<N_IN)-1:0]   expected,
  input  logic                   sop_in,
  input  logic                   pos_in,
  output logic [N_IN-1:0]        vec_out,
  output logic                   busy,
  output logic                   done,
  output logic [(1<<N_IN)-1:0]   table_sop,
  output logic [(1<<N_IN)-1:0]   table_pos,
  output logic                   mismatch,
  output logic [N_IN-1:0]        first_bad,
  output logic [N_IN:0]          bad_count,
  output logic [1:0]             dbgState
);

  localparam int              CntW    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(SETTLE - 1);
  localparam logic [N_IN-1:0] VecLast = {N_IN{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    SAMPLE = 2'd2
  } stateT;

  stateT                 state, stateNext;
  logic [CntW-1:0]       cnt, cntNext;
  logic [N_IN-1:0]       vecNext;
  logic                  busyNext, doneNext;
  logic [(1<<N_IN)-1:0]  sopNext, posNext;
  logic                  misNext;
  logic [N_IN-1:0]       firstBadNext;
  logic [N_IN:0]         badCountNext;
  logic                  vecFail;

  assign dbgState = state;

  // A vector fails once even if both implementations disagree with it.
  assign vecFail = (sop_in != expected[vec_out]) || (pos_in != expected[vec_out]);

  // Next-state and next-output logic; everything holds unless a state acts on it.
  always_comb begin
    stateNext    = state;
    cntNext      = cnt;
    vecNext      = vec_out;
    busyNext     = busy;
    doneNext     = 1'b0;
    sopNext      = table_sop;
    posNext      = table_pos;
    misNext      = mismatch;
    firstBadNext = first_bad;
    badCountNext = bad_count;
    case (state)
      IDLE: begin
        if (start) begin
          stateNext    = WAIT;
          cntNext      = '0;
          vecNext      = '0;
          busyNext     = 1'b1;
          sopNext      = '0;
          posNext      = '0;
          misNext      = 1'b0;
          firstBadNext = '0;
          badCountNext = '0;
        end
      end
      WAIT: begin
        cntNext = cnt + CntW'(1);
        if (cnt == CntLast) stateNext = SAMPLE;
      end
      SAMPLE: begin
        sopNext[vec_out] = sop_in;
        posNext[vec_out] = pos_in;
        if (vecFail) begin
          badCountNext = bad_count + (N_IN+1)'(1);
          if (!mismatch) begin
            firstBadNext = vec_out;
            misNext      = 1'b1;
          end
        end
        if (vec_out != VecLast) begin
          vecNext   = vec_out + N_IN'(1);
          cntNext   = '0;
          stateNext = WAIT;
        end else begin
          // Last vector: vec_out stays at the final value, no wrap.
          busyNext  = 1'b0;
          doneNext  = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // State register; reset aborts any sweep in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Registered outputs and settle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      vec_out   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      table_sop <= '0;
      table_pos <= '0;
      mismatch  <= 1'b0;
      first_bad <= '0;
      bad_count <= '0;
    end else begin
      cnt       <= cntNext;
      vec_out   <= vecNext;
      busy      <= busyNext;
      done      <= doneNext;
      table_sop <= sopNext;
      table_pos <= posNext;
      mismatch  <= misNext;
      first_bad <= firstBadNext;
      bad_count <= badCountNext;
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: instance 0 uses SETTLE=2, instance 1 SETTLE=1.
// The implementations under test are modelled combinationally from vec_out.
module tb_truth_table_sweeper;

  typedef struct packed {
    logic        id;
    int          e0;
    logic [15:0] tSop;
    logic [15:0] tPos;
    logic        mis;
    logic [3:0]  fb;
    logic [4:0]  bc;
  } sweepT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        startS  [2];
  logic [15:0] expd    [2];
  logic        sopIn   [2];
  logic        posIn   [2];
  logic [3:0]  vecOut  [2];
  logic        busy    [2];
  logic        done    [2];
  logic [15:0] tabSop  [2];
  logic [15:0] tabPos  [2];
  logic        mis     [2];
  logic [3:0]  firstBad[2];
  logic [4:0]  badCount[2];
  logic [1:0]  dbgState[2];
  logic [15:0] sopFlip [2];
  logic [15:0] posFlip [2];
  logic        sopStuck[2];

  sweepT expQ[$];
  int    cyc  = 0;
  int    nVec = 0;
  int    nBad = 0;

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // implementations under test: correct function with optional flips / stuck-at-0
  always_comb begin
    for (int d = 0; d < 2; d++) begin
      sopIn[d] = sopStuck[d] ? 1'b0 : (expd[d][vecOut[d]] ^ sopFlip[d][vecOut[d]]);
      posIn[d] = expd[d][vecOut[d]] ^ posFlip[d][vecOut[d]];
    end
  end

  truth_table_sweeper #(.N_IN(4), .SETTLE(2)) dut0 (
    .clk(clk), .rst(rst), .start(startS[0]), .expected(expd[0]),
    .sop_in(sopIn[0]), .pos_in(posIn[0]), .vec_out(vecOut[0]), .busy(busy[0]),
    .done(done[0]), .table_sop(tabSop[0]), .table_pos(tabPos[0]),
    .mismatch(mis[0]), .first_bad(firstBad[0]), .bad_count(badCount[0]),
    .dbgState(dbgState[0])
  );

  truth_table_sweeper #(.N_IN(4), .SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(startS[1]), .expected(expd[1]),
    .sop_in(sopIn[1]), .pos_in(posIn[1]), .vec_out(vecOut[1]), .busy(busy[1]),
    .done(done[1]), .table_sop(tabSop[1]), .table_pos(tabPos[1]),
    .mismatch(mis[1]), .first_bad(firstBad[1]), .bad_count(badCount[1]),
    .dbgState(dbgState[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    nVec++;
    if (act !== req) begin
      nBad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int settleOf(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  // Reference model: whole-table view of what a sweep must report.
  function automatic sweepT model(input int d, input int e0);
    sweepT       r;
    logic [15:0] diff;
    r    = '0;
    r.id = 1'(d);
    r.e0 = e0;
    r.tSop = sopStuck[d] ? 16'h0000 : (expd[d] ^ sopFlip[d]);
    r.tPos = expd[d] ^ posFlip[d];
    diff   = (r.tSop ^ expd[d]) | (r.tPos ^ expd[d]);
    r.bc   = 5'($countones(diff));
    r.mis  = |diff;
    for (int v = 15; v >= 0; v--) if (diff[v]) r.fb = 4'(v);
    return r;
  endfunction

  // scoreboard monitor: checks stimulus progress while busy and results at done
  always @(negedge clk) begin : monitor
    sweepT h;
    for (int d = 0; d < 2; d++) begin
      if (done[d]) begin
        if (expQ.size() == 0 || expQ[0].id != 1'(d)) begin
          nVec++;
          nBad++;
          $display("FAIL unexpected_done: dut%0d got done=1, want no sweep pending (cycle %0d)", d, cyc);
        end else begin
          h = expQ.pop_front();
          check("done_time",  32'(cyc),         32'(h.e0 + 16 * (settleOf(d) + 1)));
          check("busy_at_done", 32'(busy[d]),   32'(0));
          check("table_sop",  32'(tabSop[d]),   32'(h.tSop));
          check("table_pos",  32'(tabPos[d]),   32'(h.tPos));
          check("mismatch",   32'(mis[d]),      32'(h.mis));
          check("first_bad",  32'(firstBad[d]), 32'(h.fb));
          check("bad_count",  32'(badCount[d]), 32'(h.bc));
        end
      end else if (busy[d] && expQ.size() != 0 && expQ[0].id == 1'(d)) begin
        h = expQ[0];
        check("vec_out", 32'(vecOut[d]), 32'((cyc - h.e0) / (settleOf(d) + 1)));
      end
    end
  end

  task automatic checkZero(input int d, input string tag);
    check({tag, "_vec"},   32'(vecOut[d]),   32'(0));
    check({tag, "_busy"},  32'(busy[d]),     32'(0));
    check({tag, "_done"},  32'(done[d]),     32'(0));
    check({tag, "_tsop"},  32'(tabSop[d]),   32'(0));
    check({tag, "_tpos"},  32'(tabPos[d]),   32'(0));
    check({tag, "_mis"},   32'(mis[d]),      32'(0));
    check({tag, "_fb"},    32'(firstBad[d]), 32'(0));
    check({tag, "_bc"},    32'(badCount[d]), 32'(0));
  endtask

  // driver: one-cycle start pulse; expected sweep result pushed at issue time
  task automatic issueStart(input int d, output int e0);
    @(negedge clk);
    e0 = cyc + 1;
    expQ.push_back(model(d, e0));
    startS[d] = 1'b1;
    @(negedge clk);
    startS[d] = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    while (expQ.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (expQ.size() != 0) begin
      nVec++;
      nBad++;
      $display("FAIL %s_timeout: got %0d sweeps pending, want 0", tag, expQ.size());
      expQ.delete();
    end
    @(negedge clk);
  endtask

  task automatic setStim(input int d, input logic [15:0] e, input logic [15:0] sf,
                         input logic [15:0] pf, input logic stuck);
    expd[d]     = e;
    sopFlip[d]  = sf;
    posFlip[d]  = pf;
    sopStuck[d] = stuck;
  endtask

  initial begin
    int e0;
    for (int d = 0; d < 2; d++) begin
      startS[d] = 1'b0;
      setStim(d, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    end

    // reset state
    repeat (3) @(negedge clk);
    checkZero(0, "reset0");
    checkZero(1, "reset1");
    rst = 1'b0;

    // clean sweep
    setStim(0, 16'hA5C3, 16'h0000, 16'h0000, 1'b0);
    issueStart(0, e0);
    waitIdle("clean");
    check("clean_tsop", 32'(tabSop[0]),   32'h0000A5C3);
    check("clean_tpos", 32'(tabPos[0]),   32'h0000A5C3);
    check("clean_bc",   32'(badCount[0]), 32'(0));

    // single fault on POS at vector 5
    setStim(0, 16'hA5C3, 16'h0000, 16'h0020, 1'b0);
    issueStart(0, e0);
    waitIdle("single");
    check("single_tpos", 32'(tabPos[0]),   32'h0000A5E3);
    check("single_tsop", 32'(tabSop[0]),   32'h0000A5C3);
    check("single_mis",  32'(mis[0]),      32'(1));
    check("single_fb",   32'(firstBad[0]), 32'(5));
    check("single_bc",   32'(badCount[0]), 32'(1));

    // SOP stuck at 0
    setStim(0, 16'h00FF, 16'h0000, 16'h0000, 1'b1);
    issueStart(0, e0);
    waitIdle("stuck");
    check("stuck_bc",   32'(badCount[0]), 32'(8));
    check("stuck_fb",   32'(firstBad[0]), 32'(0));
    check("stuck_tsop", 32'(tabSop[0]),   32'(0));

    // randomized tables and fault patterns
    for (int i = 0; i < 5; i++) begin
      setStim(0, 16'($urandom),
              16'($urandom & $urandom & $urandom),
              16'($urandom & $urandom & $urandom),
              1'($urandom_range(0, 3) == 0));
      issueStart(0, e0);
      waitIdle("random");
    end

    // reset mid-sweep: asynchronous, between edges
    setStim(0, 16'h3C5A, 16'h0100, 16'h0000, 1'b0);
    issueStart(0, e0);
    while (cyc != e0 + 20) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    expQ.delete();
    #1 checkZero(0, "rstmid");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    setStim(0, 16'hA5C3, 16'h0000, 16'h0000, 1'b0);
    issueStart(0, e0);
    waitIdle("after_rst");

    // start ignored while busy; start held through done restarts at the done edge
    setStim(0, 16'hA5C3, 16'h0000, 16'h0008, 1'b0);
    issueStart(0, e0);
    while (cyc != e0 + 10) @(negedge clk);
    startS[0] = 1'b1;
    @(negedge clk);
    startS[0] = 1'b0;
    while (cyc != e0 + 40) @(negedge clk);
    expQ.push_back(model(0, e0 + 49));
    startS[0] = 1'b1;
    while (cyc != e0 + 49) @(negedge clk);
    check("restart_busy", 32'(busy[0]),     32'(1));
    check("restart_tsop", 32'(tabSop[0]),   32'(0));
    check("restart_tpos", 32'(tabPos[0]),   32'(0));
    check("restart_mis",  32'(mis[0]),      32'(0));
    check("restart_bc",   32'(badCount[0]), 32'(0));
    startS[0] = 1'b0;
    waitIdle("restart");

    // SETTLE=1 instance, clean sweep
    setStim(1, 16'hA5C3, 16'h0000, 16'h0000, 1'b0);
    issueStart(1, e0);
    waitIdle("settle1");
    check("settle1_tsop", 32'(tabSop[1]),   32'h0000A5C3);
    check("settle1_tpos", 32'(tabPos[1]),   32'h0000A5C3);
    check("settle1_bc",   32'(badCount[1]), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end

endmodule
